// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of an RV64 pipeline.
//
// Accepts one op per cycle from ex_stage when idle. There are three kinds of op:
//   - Non-memory ops pass the ALU result to write-back one cycle later.
//   - Stores drive the RAM write port in the same cycle.
//   - Loads drive the RAM read port, then spend one LOAD_WAIT cycle. In that
//     cycle the byte lane is extracted and extended, and the result is
//     registered to write-back.
// Misaligned or illegal accesses touch neither RAM nor the register file.
// They raise mem_err for one cycle.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   valid_in                    op present from ex_stage
//   mem_rd, mem_wr, funct3      load/store flags and width/sign code
//   addr, wdata                 byte address (or ALU result), store data
//   rd_en, rd_addr              destination write request / index
//   ram_rdata                   RAM doubleword, valid the cycle after ram_ren
//   ram_ren/ram_raddr           RAM read enable / aligned address
//   ram_wen/ram_waddr           RAM write enable / aligned address
//   ram_wmask/ram_wdata         bit-level byte mask / lane-shifted data
//   stall                       stage busy, upstream holds inputs
//   wb_en, wb_addr, wb_data     registered register-file write
//   mem_err                     registered one-cycle access fault pulse
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic        rd_en,
  input  logic [4:0]  rd_addr,
  input  logic [63:0] ram_rdata,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [63:0] ram_raddr,
  output logic [63:0] ram_waddr,
  output logic [63:0] ram_wmask,
  output logic [63:0] ram_wdata,
  output logic        stall,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [63:0] wb_data,
  output logic        mem_err
);

  typedef enum logic {IDLE = 1'b0, LOAD_WAIT = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  ld_funct3_reg;
  logic [2:0]  ld_off_reg;
  logic        ld_rd_en_reg;
  logic [4:0]  ld_rd_addr_reg;

  logic        is_mem, illegal, misaligned, access_err;
  logic [5:0]  lane_shift;
  logic [63:0] size_mask, load_lane, load_ext;
  logic        load_latch;
  logic        wb_en_next, mem_err_next;
  logic [4:0]  wb_addr_next;
  logic [63:0] wb_data_next;

  // Access decode for the op currently on the inputs.
  always_comb begin
    lane_shift = {addr[2:0], 3'b000};
    is_mem     = mem_rd | mem_wr;
    illegal    = (mem_rd & mem_wr) | (mem_rd & (funct3 == 3'b111)) | (mem_wr & funct3[2]);
    // funct3[1:0] encodes the access size for both loads and stores.
    case (funct3[1:0])
      2'b00: begin misaligned = 1'b0;             size_mask = 64'h0000_0000_0000_00FF; end
      2'b01: begin misaligned = addr[0];          size_mask = 64'h0000_0000_0000_FFFF; end
      2'b10: begin misaligned = |addr[1:0];       size_mask = 64'h0000_0000_FFFF_FFFF; end
      default: begin misaligned = |addr[2:0];     size_mask = 64'hFFFF_FFFF_FFFF_FFFF; end
    endcase
    access_err = is_mem & (illegal | misaligned);
  end

  // Lane extraction and sign/zero extension for the load in LOAD_WAIT.
  always_comb begin
    load_lane = ram_rdata >> {ld_off_reg, 3'b000};
    case (ld_funct3_reg)
      3'b000:  load_ext = {{56{load_lane[7]}},  load_lane[7:0]};
      3'b001:  load_ext = {{48{load_lane[15]}}, load_lane[15:0]};
      3'b010:  load_ext = {{32{load_lane[31]}}, load_lane[31:0]};
      3'b011:  load_ext = load_lane;
      3'b100:  load_ext = {56'd0, load_lane[7:0]};
      3'b101:  load_ext = {48'd0, load_lane[15:0]};
      3'b110:  load_ext = {32'd0, load_lane[31:0]};
      default: load_ext = 64'd0;
    endcase
  end

  // Next-state and outputs.
  always_comb begin
    state_next   = state_reg;
    stall        = 1'b0;
    ram_ren      = 1'b0;
    ram_wen      = 1'b0;
    ram_raddr    = {addr[63:3], 3'b000};
    ram_waddr    = {addr[63:3], 3'b000};
    ram_wmask    = size_mask << lane_shift;
    ram_wdata    = wdata << lane_shift;
    load_latch   = 1'b0;
    wb_en_next   = 1'b0;
    wb_addr_next = 5'd0;
    wb_data_next = 64'd0;
    mem_err_next = 1'b0;
    if (rst) begin
      // Reset keeps every enable low, so a pending load is simply dropped.
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (valid_in) begin
            if (!is_mem) begin
              wb_en_next   = rd_en & (|rd_addr);
              wb_addr_next = rd_addr;
              wb_data_next = addr;
            end else if (access_err) begin
              mem_err_next = 1'b1;
            end else if (mem_wr) begin
              ram_wen = 1'b1;
            end else begin
              ram_ren    = 1'b1;
              load_latch = 1'b1;
              state_next = LOAD_WAIT;
            end
          end
        end
        LOAD_WAIT: begin
          stall        = 1'b1;
          wb_en_next   = ld_rd_en_reg & (|ld_rd_addr_reg);
          wb_addr_next = ld_rd_addr_reg;
          wb_data_next = load_ext;
          state_next   = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      wb_en          <= 1'b0;
      wb_addr        <= 5'd0;
      wb_data        <= 64'd0;
      mem_err        <= 1'b0;
      ld_funct3_reg  <= 3'd0;
      ld_off_reg     <= 3'd0;
      ld_rd_en_reg   <= 1'b0;
      ld_rd_addr_reg <= 5'd0;
    end else begin
      state_reg <= state_next;
      wb_en     <= wb_en_next;
      wb_addr   <= wb_addr_next;
      wb_data   <= wb_data_next;
      mem_err   <= mem_err_next;
      if (load_latch) begin
        ld_funct3_reg  <= funct3;
        ld_off_reg     <= addr[2:0];
        ld_rd_en_reg   <= rd_en;
        ld_rd_addr_reg <= rd_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized plus directed bench for mem_stage.
// An op-level reference model predicts the same-cycle RAM port and stall
// values. It also predicts the next-cycle write-back/error outputs.
// Each cycle, the step task drives inputs on the falling edge.
// It then checks against the model.
// Directed ops pin the model with hand-computed literals.
module tb_mem_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid_in, mem_rd, mem_wr, rd_en;
  logic [2:0]  funct3;
  logic [63:0] addr, wdata, ram_rdata;
  logic [4:0]  rd_addr;
  logic        ram_ren, ram_wen, stall, wb_en, mem_err;
  logic [63:0] ram_raddr, ram_waddr, ram_wmask, ram_wdata, wb_data;
  logic [4:0]  wb_addr;

  mem_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rd_en(rd_en), .rd_addr(rd_addr),
    .ram_rdata(ram_rdata), .ram_ren(ram_ren), .ram_wen(ram_wen),
    .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_wmask(ram_wmask),
    .ram_wdata(ram_wdata), .stall(stall), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .mem_err(mem_err)
  );

  int checks = 0;
  int failures = 0;
  int txn = 0;

  // Model: one pending load, plus the write-back expected after this edge.
  bit          primed = 1'b0;
  bit          m_busy = 1'b0;
  int          m_f3, m_off, m_rd;
  bit          m_rd_en;
  bit          e_wb_en, e_err, e_chk_data;
  logic [4:0]  e_wb_addr;
  logic [63:0] e_wb_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] width_mask(input int bytes);
    if (bytes >= 8) return '1;
    return (64'd1 << (8 * bytes)) - 64'd1;
  endfunction

  task automatic step(input bit r, input bit v, input bit mr, input bit mw,
                      input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                      input bit re, input logic [4:0] rd, input logic [63:0] rdata);
    logic [63:0] lane, msk, val, x_raddr, x_waddr, x_wmask, x_wdata, n_data;
    logic [4:0]  n_addr;
    int          bytes, off;
    bit          legal, aligned, x_ren, x_wen, x_stall, n_en, n_err, n_chk;
    @(negedge clk);
    if (primed) begin
      chk("wb_en", wb_en, e_wb_en);
      chk("mem_err", mem_err, e_err);
      if (e_chk_data) begin
        chk("wb_addr", wb_addr, e_wb_addr);
        chk("wb_data", wb_data, e_wb_data);
      end
    end
    rst = r; valid_in = v; mem_rd = mr; mem_wr = mw; funct3 = f3; addr = a;
    wdata = wd; rd_en = re; rd_addr = rd; ram_rdata = rdata;
    #1;
    x_ren = 0; x_wen = 0; x_stall = 0;
    x_raddr = 0; x_waddr = 0; x_wmask = 0; x_wdata = 0;
    n_en = 0; n_err = 0; n_chk = 0; n_addr = 0; n_data = 0;
    if (r) begin
      m_busy = 0;
      n_chk = 1;
    end else if (m_busy) begin
      x_stall = 1;
      bytes = 1 << (m_f3 % 4);
      lane = rdata >> (8 * m_off);
      msk = width_mask(bytes);
      val = lane & msk;
      if (m_f3 < 4 && bytes < 8 && val[8 * bytes - 1]) val = val | ~msk;
      n_en = m_rd_en && (m_rd != 0);
      n_addr = 5'(m_rd);
      n_data = val;
      n_chk = n_en;
      m_busy = 0;
    end else if (v) begin
      txn++;
      $display("txn %0d: rd=%0b wr=%0b f3=%0d addr=%h wdata=%h rd_en=%0b rd=%0d",
               txn, mr, mw, f3, a, wd, re, rd);
      off = int'(a % 64'd8);
      if (!mr && !mw) begin
        n_en = re && (rd != 0);
        n_addr = rd;
        n_data = a;
        n_chk = n_en;
      end else begin
        bytes = 1 << (f3 % 4);
        legal = !(mr && mw) && !(mr && f3 == 3'd7) && !(mw && f3 >= 3'd4);
        aligned = (a % 64'(bytes)) == 0;
        if (!legal || !aligned) begin
          n_err = 1;
        end else if (mw) begin
          x_wen = 1;
          x_waddr = a - 64'(off);
          x_wdata = wd << (8 * off);
          x_wmask = width_mask(bytes) << (8 * off);
        end else begin
          x_ren = 1;
          x_raddr = a - 64'(off);
          m_busy = 1; m_f3 = int'(f3); m_off = off; m_rd_en = re; m_rd = int'(rd);
        end
      end
    end
    chk("stall", stall, x_stall);
    chk("ram_ren", ram_ren, x_ren);
    chk("ram_wen", ram_wen, x_wen);
    if (x_wen) begin
      chk("ram_waddr", ram_waddr, x_waddr);
      chk("ram_wmask", ram_wmask, x_wmask);
      chk("ram_wdata", ram_wdata, x_wdata);
    end
    if (x_ren) chk("ram_raddr", ram_raddr, x_raddr);
    e_wb_en = n_en; e_err = n_err; e_chk_data = n_chk; e_wb_addr = n_addr; e_wb_data = n_data;
    primed = 1;
  endtask

  task automatic idle(input logic [63:0] rdata);
    step(0, 0, 0, 0, 3'd0, 64'd0, 64'd0, 0, 5'd0, rdata);
  endtask

  logic [63:0] ra, rw;
  int sel, sz;
  bit rmr, rmw;
  logic [2:0] rf3;

  initial begin
    step(1, 0, 0, 0, 3'd0, 64'd0, 64'd0, 0, 5'd0, 64'd0);
    step(1, 1, 1, 0, 3'd3, 64'd0, 64'd0, 1, 5'd1, 64'd0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_ren", ram_ren, 1'b0);
    idle(64'd0);
    chk("reset_wb_en", wb_en, 1'b0);
    chk("reset_wb_data", wb_data, 64'd0);
    chk("reset_mem_err", mem_err, 1'b0);

    // ALU op to x5.
    step(0, 1, 0, 0, 3'd0, 64'h1234, 64'd0, 1, 5'd5, 64'd0);
    idle(64'd0);
    chk("alu_wb_en", wb_en, 1'b1);
    chk("alu_wb_addr", wb_addr, 5'd5);
    chk("alu_wb_data", wb_data, 64'h1234);
    chk("alu_ren", ram_ren, 1'b0);
    chk("alu_wen", ram_wen, 1'b0);

    // ALU op to x0 never writes back.
    step(0, 1, 0, 0, 3'd0, 64'h77, 64'd0, 1, 5'd0, 64'd0);
    idle(64'd0);
    chk("x0_wb_en", wb_en, 1'b0);

    // SB at byte offset 3.
    step(0, 1, 0, 1, 3'b000, 64'h8000_0003, 64'hAB, 0, 5'd0, 64'd0);
    chk("sb_wen", ram_wen, 1'b1);
    chk("sb_waddr", ram_waddr, 64'h8000_0000);
    chk("sb_wmask", ram_wmask, 64'h0000_0000_FF00_0000);
    chk("sb_wdata", ram_wdata, 64'hAB00_0000);
    idle(64'd0);
    chk("sb_wb_en", wb_en, 1'b0);

    // LH / LHU at offset 6, upper half of the doubleword.
    step(0, 1, 1, 0, 3'b001, 64'h8000_0006, 64'd0, 1, 5'd7, 64'd0);
    chk("lh_ren", ram_ren, 1'b1);
    chk("lh_raddr", ram_raddr, 64'h8000_0000);
    idle(64'h8001_0000_0000_0000);
    chk("lh_stall", stall, 1'b1);
    idle(64'd0);
    chk("lh_stall_done", stall, 1'b0);
    chk("lh_wb_en", wb_en, 1'b1);
    chk("lh_wb_data", wb_data, 64'hFFFF_FFFF_FFFF_8001);
    step(0, 1, 1, 0, 3'b101, 64'h8000_0006, 64'd0, 1, 5'd7, 64'd0);
    idle(64'h8001_0000_0000_0000);
    idle(64'd0);
    chk("lhu_wb_data", wb_data, 64'h0000_0000_0000_8001);

    // Misaligned LW.
    step(0, 1, 1, 0, 3'b010, 64'h8000_0002, 64'd0, 1, 5'd8, 64'd0);
    chk("lw_mis_ren", ram_ren, 1'b0);
    idle(64'd0);
    chk("lw_mis_err", mem_err, 1'b1);
    chk("lw_mis_wb_en", wb_en, 1'b0);
    chk("lw_mis_stall", stall, 1'b0);

    // LD followed by an ALU op that is held through the stall.
    step(0, 1, 1, 0, 3'b011, 64'h8000_0010, 64'd0, 1, 5'd3, 64'd0);
    step(0, 1, 0, 0, 3'd0, 64'h55, 64'd0, 1, 5'd4, 64'h1122_3344_5566_7788);
    chk("b2b_stall", stall, 1'b1);
    step(0, 1, 0, 0, 3'd0, 64'h55, 64'd0, 1, 5'd4, 64'd0);
    chk("b2b_accept", stall, 1'b0);
    chk("b2b_ld_addr", wb_addr, 5'd3);
    chk("b2b_ld_data", wb_data, 64'h1122_3344_5566_7788);
    idle(64'd0);
    chk("b2b_alu_en", wb_en, 1'b1);
    chk("b2b_alu_addr", wb_addr, 5'd4);
    chk("b2b_alu_data", wb_data, 64'h55);

    // Reset while waiting on a load discards it.
    step(0, 1, 1, 0, 3'b011, 64'h8000_0018, 64'd0, 1, 5'd9, 64'd0);
    step(1, 0, 0, 0, 3'd0, 64'd0, 64'd0, 0, 5'd0, 64'hDEAD_BEEF);
    chk("rstw_stall", stall, 1'b0);
    idle(64'd0);
    chk("rstw_wb_en", wb_en, 1'b0);
    chk("rstw_stall_after", stall, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 9);
      rmr = (sel >= 4 && sel <= 6) || sel == 9;
      rmw = (sel >= 7);
      if (rmw && !rmr) rf3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      else rf3 = 3'($urandom_range(0, 7));
      ra = {$urandom, $urandom};
      rw = {$urandom, $urandom};
      if ((rmr || rmw) && $urandom_range(0, 3) != 0) begin
        sz = 1 << (rf3 % 4);
        ra = ra - (ra % 64'(sz));
      end
      step($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0, rmr, rmw, rf3, ra, rw,
           $urandom_range(0, 5) != 0, 5'($urandom_range(0, 31)), {$urandom, $urandom});
    end
    idle(64'd0);
    idle(64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 valid_in  in  1  op from ex_stage present this cycle.
REQ-004 mem_rd  in  1  op is a load.
REQ-005 mem_wr  in  1  op is a store.
REQ-006 funct3  in  3  RV64 width/sign code of load/store.
REQ-007 addr  in  64  ALU result: byte address for memory ops, result value for non-memory ops.
REQ-008 wdata  in  64  store data (rs2 value).
REQ-009 rd_en / rd_addr  in  1 / 5  destination register write request / index.
REQ-010 ram_rdata  in  64  RAM doubleword; valid the cycle after ram_ren.
REQ-011 ram_ren, ram_wen  out  1  RAM read / write enable.
REQ-012 ram_raddr, ram_waddr  out  64  RAM byte address, always 8-byte aligned.
REQ-013 ram_wmask  out  64  bit-level write mask, 8'hFF per written byte.
REQ-014 ram_wdata  out  64  store data shifted to its byte lane.
REQ-015 stall  out  1  stage busy; upstream holds its inputs.
REQ-016 wb_en / wb_addr / wb_data  out  1 / 5 / 64  registered write-back to Regfile.
REQ-017 mem_err  out  1  registered one-cycle pulse: misaligned or illegal access.

Function
REQ-018 FSM has two states: IDLE and LOAD_WAIT; inputs are accepted only in IDLE when valid_in=1.
REQ-019 stall SHALL equal (state==LOAD_WAIT), combinational.
REQ-020 Accepted non-memory op: next cycle wb_en=rd_en, wb_addr=rd_addr, wb_data=addr (latency 1).
REQ-021 Accepted store: same cycle ram_wen=1, ram_waddr={addr[63:3],3'b0}, ram_wdata=wdata<<(8*addr[2:0]), mask width per funct3 (000 byte, 001 half, 010 word, 011 double) shifted likewise; next cycle wb_en=0.
REQ-022 Accepted load: same cycle ram_ren=1, ram_raddr={addr[63:3],3'b0}; funct3, addr[2:0], rd_en, rd_addr latched; state->LOAD_WAIT.
REQ-023 In LOAD_WAIT: extract lane from ram_rdata>>(8*off), extend per funct3 (000 LB, 001 LH, 010 LW sign; 011 LD; 100 LBU, 101 LHU, 110 LWU zero); register to wb_* at end of cycle; state->IDLE (load latency 2, wb valid cycle after LOAD_WAIT).
REQ-024 ram_ren, ram_wen SHALL be 0 in every cycle not named in REQ-021/REQ-022; at most one is high in any cycle.
REQ-025 Misaligned: half with addr[0]!=0, word with addr[1:0]!=0, double with addr[2:0]!=0 -> no RAM enable, no wb, mem_err=1 next cycle, stay IDLE.
REQ-026 Illegal: funct3=111 on load, funct3[2]=1 on store, or mem_rd&mem_wr -> treated as REQ-025.
REQ-027 wb_en SHALL be forced 0 when the destination index is 0.
REQ-028 wb_* and mem_err hold for exactly one cycle per op; with valid_in=0 in IDLE, next cycle wb_en=0, mem_err=0.
REQ-029 Inputs presented while stall=1 SHALL be ignored and not consumed.

Reset
REQ-030 rst=1 at a rising edge: state=IDLE, wb_en=0, wb_addr=0, wb_data=0, mem_err=0, latched load fields=0.
REQ-031 While rst=1, ram_ren=ram_wen=0, stall=0; a load in LOAD_WAIT is discarded without write-back.

Verification
REQ-032 ALU op addr=0x1234, rd=5, rd_en=1 -> next cycle wb_en=1, wb_addr=5, wb_data=0x1234, ram_ren=ram_wen=0.
REQ-033 SB addr=0x80000003, wdata=0xAB -> same cycle ram_wen=1, ram_waddr=0x80000000, ram_wmask=0x00000000FF000000, ram_wdata=0xAB000000.
REQ-034 LH addr=0x80000006, ram_rdata=0x8001_0000_0000_0000 -> stall=1 one cycle, then wb_data=0xFFFFFFFFFFFF8001; LHU same -> 0x0000000000008001.
REQ-035 LW addr=0x80000002 -> ram_ren=0, mem_err=1 next cycle, wb_en=0, stall=0.
REQ-036 Back-to-back LD then ALU op held during stall -> ALU op accepted only after LOAD_WAIT; wb order LD then ALU, none lost.
REQ-037 rst asserted during LOAD_WAIT -> next cycle state IDLE, wb_en=0, stall=0, no write-back of the load.
